// File: rtl/lin_pkg.sv
// rtl/lin_pkg.sv - shared types and helpers for the LIN frame transmitter
package lin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BREAK,
    ST_DELIM,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CHK
  } lin_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'h55;

  function automatic logic [7:0] pid_parity(input logic [5:0] id);
    logic p0;
    logic p1;
    p0 = id[0] ^ id[1] ^ id[2] ^ id[4];
    p1 = ~(id[1] ^ id[3] ^ id[4] ^ id[5]);
    return {p1, p0, id};
  endfunction

  // Add with the carry out of bit 7 folded back into bit 0; result always has bit 8 clear.
  function automatic logic [8:0] chk_add(input logic [8:0] acc, input logic [7:0] b);
    logic [8:0] s;
    s = acc + {1'b0, b};
    return {1'b0, s[7:0] + {7'd0, s[8]}};
  endfunction

endpackage

// File: rtl/lin_bit_timer.sv
// rtl/lin_bit_timer.sv - bit-period divider emitting a one-cycle bit_tick
module lin_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic sys_clk,
  input  logic rstn,
  input  logic restart,
  input  logic run,
  output logic bit_tick
);

  localparam int DW = $clog2(CLKS_PER_BIT);

  logic [DW-1:0] div;

  assign bit_tick = run && (div == DW'(CLKS_PER_BIT - 1));

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn)                   div <= '0;
    else if (restart || bit_tick) div <= '0;
    else if (run)                div <= div + 1'b1;
  end

endmodule

// File: rtl/lin_frame_tx.sv
// rtl/lin_frame_tx.sv - LIN frame serialiser: break, delimiter, sync, PID, data, checksum
module lin_frame_tx
  import lin_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int MAX_BYTES    = 8,
  parameter int BREAK_BITS   = 13
) (
  input  logic                   sys_clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [5:0]             pid,
  input  logic [8*MAX_BYTES-1:0] data,
  input  logic [3:0]             len,
  input  logic                   enh_chk,
  output logic                   sdo,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             pid_prot,
  output logic [7:0]             chk
);

  localparam int BCW = $clog2(MAX_BYTES + 1);
  localparam int CW  = $clog2(BREAK_BITS + 1);

  lin_state_e             state, state_nxt;
  logic [CW-1:0]          bit_cnt;
  logic [BCW-1:0]         byte_cnt;
  logic [8*MAX_BYTES-1:0] data_sh;
  logic [3:0]             len_q;
  logic [8:0]             acc;
  logic [8:0]             acc_nxt;
  logic [7:0]             tx_byte;
  logic                   accept, bit_tick, char_end, last_byte, field_end;

  assign accept    = (state == ST_IDLE) && start;
  assign char_end  = bit_tick && (bit_cnt == CW'(9));
  assign last_byte = (4'(byte_cnt) == len_q - 4'd1);
  assign acc_nxt   = chk_add(acc, data_sh[7:0]);
  assign field_end = (state_nxt != state) || ((state == ST_DATA) && char_end);

  lin_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .sys_clk  (sys_clk),
    .rstn     (rstn),
    .restart  (accept),
    .run      (busy),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_BREAK;
      ST_BREAK: if (bit_tick && bit_cnt == CW'(BREAK_BITS - 1)) state_nxt = ST_DELIM;
      ST_DELIM: if (bit_tick) state_nxt = ST_SYNC;
      ST_SYNC:  if (char_end) state_nxt = ST_PID;
      ST_PID:   if (char_end) state_nxt = (len_q == 4'd0) ? ST_IDLE : ST_DATA;
      ST_DATA:  if (char_end && last_byte) state_nxt = ST_CHK;
      ST_CHK:   if (char_end) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != ST_IDLE);
    tx_byte = 8'h00;
    case (state)
      ST_SYNC: tx_byte = SYNC_BYTE;
      ST_PID:  tx_byte = pid_prot;
      ST_DATA: tx_byte = data_sh[7:0];
      ST_CHK:  tx_byte = chk;
      default: tx_byte = 8'h00;
    endcase
    case (state)
      ST_IDLE:  sdo = 1'b1;
      ST_BREAK: sdo = 1'b0;
      ST_DELIM: sdo = 1'b1;
      default: begin
        if (bit_cnt == CW'(0))      sdo = 1'b0;
        else if (bit_cnt == CW'(9)) sdo = 1'b1;
        else                        sdo = tx_byte[3'(bit_cnt - CW'(1))];
      end
    endcase
  end

  // Data bytes shift down so the byte on the line is always data_sh[7:0].
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      done     <= 1'b0;
      pid_prot <= 8'h00;
      chk      <= 8'h00;
      data_sh  <= '0;
      len_q    <= 4'd0;
      acc      <= 9'd0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      done <= (state != ST_IDLE) && (state_nxt == ST_IDLE);
      if (accept) begin
        pid_prot <= pid_parity(pid);
        data_sh  <= data;
        len_q    <= (len > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : len;
        acc      <= enh_chk ? {1'b0, pid_parity(pid)} : 9'd0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (bit_tick) begin
        bit_cnt <= field_end ? '0 : bit_cnt + 1'b1;
        if (state == ST_DATA && char_end) begin
          acc      <= acc_nxt;
          data_sh  <= data_sh >> 8;
          byte_cnt <= byte_cnt + 1'b1;
          if (last_byte) chk <= ~acc_nxt[7:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_lin_frame_tx.sv
// tb/tb_lin_frame_tx.sv - directed self-checking bench for lin_frame_tx
module tb_lin_frame_tx;

  localparam int CPB = 16;
  localparam int BRK = 13;

  logic        sys_clk = 1'b0;
  logic        rstn    = 1'b1;
  logic        start   = 1'b0;
  logic [5:0]  pid     = '0;
  logic [63:0] data    = '0;
  logic [3:0]  len     = '0;
  logic        enh_chk = 1'b0;
  logic        sdo, busy, done;
  logic [7:0]  pid_prot, chk;

  int total = 0;
  int bad   = 0;

  logic       exp_bits [0:255];
  int         nbits;
  logic [7:0] exp_bytes [$];

  lin_frame_tx #(.CLKS_PER_BIT(CPB), .MAX_BYTES(8), .BREAK_BITS(BRK)) dut (
    .sys_clk  (sys_clk),
    .rstn     (rstn),
    .start    (start),
    .pid      (pid),
    .data     (data),
    .len      (len),
    .enh_chk  (enh_chk),
    .sdo      (sdo),
    .busy     (busy),
    .done     (done),
    .pid_prot (pid_prot),
    .chk      (chk)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic build_exp();
    nbits = 0;
    for (int i = 0; i < BRK; i++) begin exp_bits[nbits] = 1'b0; nbits++; end
    exp_bits[nbits] = 1'b1; nbits++;
    foreach (exp_bytes[k]) begin
      exp_bits[nbits] = 1'b0; nbits++;
      for (int b = 0; b < 8; b++) begin exp_bits[nbits] = exp_bytes[k][b]; nbits++; end
      exp_bits[nbits] = 1'b1; nbits++;
    end
  endtask

  task automatic launch(input logic [5:0] p, input logic [63:0] d, input logic [3:0] l, input logic e);
    @(negedge sys_clk);
    pid = p; data = d; len = l; enh_chk = e; start = 1'b1;
  endtask

  // Records one frame cycle by cycle (cycle 1 = first cycle after acceptance).
  task automatic capture(input int pulse_at, input bit release_start, input int max_cyc,
                         output int done_cyc, output int bad_cyc, output int busy_bad);
    logic exp_sdo;
    done_cyc = -1; bad_cyc = -1; busy_bad = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge sys_clk);
      if (c == pulse_at) start = 1'b1;
      else if (release_start && (c == 1 || c == pulse_at + 1)) start = 1'b0;
      exp_sdo = (c <= nbits * CPB) ? exp_bits[(c - 1) / CPB] : 1'b1;
      if (sdo !== exp_sdo && bad_cyc < 0) bad_cyc = c;
      if (done === 1'b1) begin
        done_cyc = c;
        if (busy !== 1'b0 && busy_bad < 0) busy_bad = c;
        break;
      end
      if (busy !== 1'b1 && busy_bad < 0) busy_bad = c;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    total++; if (sdo !== 1'b1) begin bad++; $display("FAIL reset_sdo: got %b expected 1", sdo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    total++; if (pid_prot !== 8'h00) begin bad++; $display("FAIL reset_pid_prot: got %h expected 00", pid_prot); end
    total++; if (chk !== 8'h00) begin bad++; $display("FAIL reset_chk: got %h expected 00", chk); end
    rstn = 1'b1;
  endtask

  task automatic test_header();
    int dc, bc, bb;
    exp_bytes = '{8'h55, 8'h3C}; build_exp();
    launch(6'h3C, 64'h0, 4'd0, 1'b0);
    capture(-1, 1'b1, 2100, dc, bc, bb);
    total++; if (pid_prot !== 8'h3C) begin bad++; $display("FAIL hdr_pid_prot: got %h expected 3c", pid_prot); end
    total++; if (dc !== 545) begin bad++; $display("FAIL hdr_done_cycle: got %0d expected 545", dc); end
    total++; if (bc !== -1) begin bad++; $display("FAIL hdr_stream: sdo wrong at cycle %0d expected none", bc); end
    total++; if (bb !== -1) begin bad++; $display("FAIL hdr_busy: busy wrong at cycle %0d expected none", bb); end
    @(negedge sys_clk);
    total++; if ({done, busy, sdo} !== 3'b001) begin bad++; $display("FAIL hdr_idle_after: got done,busy,sdo=%b expected 001", {done, busy, sdo}); end
  endtask

  task automatic test_classic();
    int dc, bc, bb;
    exp_bytes = '{8'h55, 8'h3C, 8'h01, 8'h02, 8'hFC}; build_exp();
    launch(6'h3C, 64'h0201, 4'd2, 1'b0);
    capture(-1, 1'b1, 2100, dc, bc, bb);
    total++; if (chk !== 8'hFC) begin bad++; $display("FAIL classic_chk: got %h expected fc", chk); end
    total++; if (dc !== 1025) begin bad++; $display("FAIL classic_done_cycle: got %0d expected 1025", dc); end
    total++; if (bc !== -1) begin bad++; $display("FAIL classic_stream: sdo wrong at cycle %0d expected none", bc); end
    total++; if (bb !== -1) begin bad++; $display("FAIL classic_busy: busy wrong at cycle %0d expected none", bb); end
  endtask

  task automatic test_enhanced();
    int dc, bc, bb;
    exp_bytes = '{8'h55, 8'h3C, 8'h01, 8'h02, 8'hC0}; build_exp();
    launch(6'h3C, 64'h0201, 4'd2, 1'b1);
    capture(-1, 1'b1, 2100, dc, bc, bb);
    total++; if (chk !== 8'hC0) begin bad++; $display("FAIL enh_chk: got %h expected c0", chk); end
    total++; if (bc !== -1) begin bad++; $display("FAIL enh_stream: sdo wrong at cycle %0d expected none", bc); end
    exp_bytes = '{8'h55, 8'hC1, 8'h01, 8'h02, 8'h3B}; build_exp();
    launch(6'h01, 64'h0201, 4'd2, 1'b1);
    capture(-1, 1'b1, 2100, dc, bc, bb);
    total++; if (pid_prot !== 8'hC1) begin bad++; $display("FAIL enh_pid_prot: got %h expected c1", pid_prot); end
    total++; if (chk !== 8'h3B) begin bad++; $display("FAIL enh_chk_pid01: got %h expected 3b", chk); end
    total++; if (bc !== -1) begin bad++; $display("FAIL enh_stream_pid01: sdo wrong at cycle %0d expected none", bc); end
  endtask

  task automatic test_carry();
    int dc, bc, bb;
    exp_bytes = '{8'h55, 8'h3C, 8'hFF, 8'h02, 8'hFD}; build_exp();
    launch(6'h3C, 64'h02FF, 4'd2, 1'b0);
    capture(-1, 1'b1, 2100, dc, bc, bb);
    total++; if (chk !== 8'hFD) begin bad++; $display("FAIL carry_chk: got %h expected fd", chk); end
    total++; if (bc !== -1) begin bad++; $display("FAIL carry_stream: sdo wrong at cycle %0d expected none", bc); end
  endtask

  task automatic test_len_clamp();
    int dc, bc, bb;
    exp_bytes = '{8'h55, 8'h3C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    build_exp();
    launch(6'h3C, 64'h8877665544332211, 4'd9, 1'b0);
    capture(-1, 1'b1, 2100, dc, bc, bb);
    total++; if (dc !== 1985) begin bad++; $display("FAIL clamp_done_cycle: got %0d expected 1985", dc); end
    total++; if (chk !== 8'h99) begin bad++; $display("FAIL clamp_chk: got %h expected 99", chk); end
    total++; if (bc !== -1) begin bad++; $display("FAIL clamp_stream: sdo wrong at cycle %0d expected none", bc); end
  endtask

  task automatic test_mid_start();
    int dc, bc, bb;
    exp_bytes = '{8'h55, 8'h3C}; build_exp();
    launch(6'h3C, 64'h0, 4'd0, 1'b0);
    fork
      capture(300, 1'b1, 2100, dc, bc, bb);
      begin
        repeat (10) @(negedge sys_clk);
        pid = 6'h01; len = 4'd2; enh_chk = 1'b1;
      end
    join
    total++; if (dc !== 545) begin bad++; $display("FAIL mid_done_cycle: got %0d expected 545", dc); end
    total++; if (bc !== -1) begin bad++; $display("FAIL mid_stream: sdo wrong at cycle %0d expected none", bc); end
    total++; if (pid_prot !== 8'h3C) begin bad++; $display("FAIL mid_pid_prot: got %h expected 3c", pid_prot); end
    @(negedge sys_clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_no_queue: got busy=%b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int dc, bc, bb;
    exp_bytes = '{8'h55, 8'h3C, 8'hA5, 8'h5A}; build_exp();
    launch(6'h3C, 64'hA5, 4'd1, 1'b0);
    fork
      capture(-1, 1'b0, 2100, dc, bc, bb);
      begin
        repeat (100) @(negedge sys_clk);
        pid = 6'h01; len = 4'd0; data = 64'h0;
      end
    join
    total++; if (dc !== 865) begin bad++; $display("FAIL b2b_a_done_cycle: got %0d expected 865", dc); end
    total++; if (bc !== -1) begin bad++; $display("FAIL b2b_a_stream: sdo wrong at cycle %0d expected none", bc); end
    total++; if (bb !== -1) begin bad++; $display("FAIL b2b_a_busy: busy wrong at cycle %0d expected none", bb); end
    exp_bytes = '{8'h55, 8'hC1}; build_exp();
    capture(-1, 1'b1, 2100, dc, bc, bb);
    total++; if (dc !== 545) begin bad++; $display("FAIL b2b_b_done_cycle: got %0d expected 545", dc); end
    total++; if (bc !== -1) begin bad++; $display("FAIL b2b_b_stream: sdo wrong at cycle %0d expected none", bc); end
    total++; if (bb !== -1) begin bad++; $display("FAIL b2b_b_busy: busy wrong at cycle %0d expected none", bb); end
    total++; if (pid_prot !== 8'hC1) begin bad++; $display("FAIL b2b_b_pid_prot: got %h expected c1", pid_prot); end
    total++; if (chk !== 8'h5A) begin bad++; $display("FAIL b2b_chk_held: got %h expected 5a", chk); end
  endtask

  task automatic test_reset_mid_data();
    int dc, bc, bb;
    exp_bytes = '{8'h55, 8'h3C, 8'h01, 8'h02, 8'hFC}; build_exp();
    launch(6'h3C, 64'h0201, 4'd2, 1'b0);
    capture(-1, 1'b1, 550, dc, bc, bb);
    total++; if (bc !== -1) begin bad++; $display("FAIL rst_pre_stream: sdo wrong at cycle %0d expected none", bc); end
    rstn = 1'b0;
    #1;
    total++; if ({sdo, busy, done} !== 3'b100) begin bad++; $display("FAIL rst_async_outputs: got sdo,busy,done=%b expected 100", {sdo, busy, done}); end
    total++; if ({pid_prot, chk} !== 16'h0000) begin bad++; $display("FAIL rst_async_regs: got %h expected 0000", {pid_prot, chk}); end
    @(negedge sys_clk);
    rstn = 1'b1;
    launch(6'h3C, 64'h0201, 4'd2, 1'b0);
    capture(-1, 1'b1, 2100, dc, bc, bb);
    total++; if (dc !== 1025) begin bad++; $display("FAIL rst_post_done_cycle: got %0d expected 1025", dc); end
    total++; if (bc !== -1) begin bad++; $display("FAIL rst_post_stream: sdo wrong at cycle %0d expected none", bc); end
    total++; if (chk !== 8'hFC) begin bad++; $display("FAIL rst_post_chk: got %h expected fc", chk); end
  endtask

  initial begin
    #1 rstn = 1'b0;
    test_reset();
    test_header();
    test_classic();
    test_enhanced();
    test_carry();
    test_len_clamp();
    test_mid_start();
    test_back_to_back();
    test_reset_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
